qoi_stream_ctrl: RTL and testbench
==================================

Name: qoi_stream_ctrl

Overview:
Sequences one QOI image through the clock-enabled qoi_encoder and produces a complete byte stream on a valid/ready byte port. The stream is a 14-byte header, the encoder chunks, then an 8-byte end marker. The block sits between the pixel source and the output byte sink. It owns the encoder's reset, clock enable and finish, and back-pressures pixels whenever the byte sink stalls.

Parameters:
- DIM_W, 32: width of the image dimension fields and the pixel counter.
- FLUSH_ADV, 2: encoder advances issued after the last pixel to drain the encoder pipeline.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin an image; ignored while busy.
- cfg_width  in  DIM_W  image width; sampled on start.
- cfg_height  in  DIM_W  image height; sampled on start.
- cfg_channels  in  8  header channels byte.
- cfg_colorspace  in  8  header colorspace byte.
- s_px  in  32  {r,g,b,a} input pixel.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when s_valid & s_ready.
- enc_rst  out  1  encoder reset.
- enc_ce  out  1  encoder clock enable; encoder state advances only on enc_ce cycles.
- enc_px  out  32  pixel presented to the encoder.
- enc_finish  out  1  encoder finish flag.
- enc_chunk  in  40  encoder chunk; byte0 in [7:0].
- enc_chunk_len  in  3  encoder chunk length, 0..5.
- m_data  out  8  output byte.
- m_valid  out  1  output byte valid.
- m_ready  in  1  output byte accepted when m_valid & m_ready.
- m_last  out  1  marks the final trailer byte 0x01.
- busy  out  1  high from start until the last byte is accepted.
- done  out  1  one-cycle pulse after m_last is accepted.

Behaviour:
- Reset values: all outputs 0 except enc_rst=1. State goes to IDLE. Holding register is emptied.
- Reset mid-image: same result; any partial stream is abandoned with no m_last.
- IDLE → ENC_RST on start. The cfg_* fields are latched and the pixel counter loads width*height, truncated to DIM_W.
- ENC_RST: enc_rst=1 for exactly one cycle, then → HEADER.
- HEADER emits 14 bytes, advancing one byte per accepted transfer:
  - 0x71 0x6F 0x69 0x66;
  - width big-endian;
  - height big-endian;
  - channels;
  - colorspace.
- At the end of HEADER: → STREAM if the counter is non-zero, otherwise → TRAILER.
- Holding register: 5 bytes, a length and a read index.
  - m_data is the byte at the read index; m_valid=1 while the register is non-empty.
- Advance condition: can_adv = the holding register is empty, or it holds 1 byte and m_ready=1.
- STREAM:
  - s_ready=can_adv, enc_ce=s_valid&can_adv, and enc_px=s_px combinationally.
  - On every enc_ce cycle, the current enc_chunk/enc_chunk_len are captured into the holding register. A length of 0 leaves the register empty.
  - Each accepted pixel decrements the counter. When it reaches 0, → FLUSH.
- FLUSH:
  - Issues FLUSH_ADV advances, each gated by can_adv, with enc_px=0.
  - enc_finish=1 on the first flush advance only.
  - Chunks are captured exactly as in STREAM.
  - After the last advance, once the holding register is empty, → TRAILER.
- TRAILER: emits 0x00 ×7 then 0x01; m_last=1 with the final byte. On its acceptance → IDLE and done=1.
- m_data/m_valid stay stable while m_valid & !m_ready. No byte is lost or duplicated.
- enc_ce=0 outside STREAM/FLUSH.

Optional Feature:
- Macro: QOI_STREAM_CTRL_STATS_EN.
- When defined, adds two outputs, cleared on start:
  - stat_bytes [31:0]: count of all accepted output bytes, header and trailer included.
  - stat_chunks [31:0]: count of non-zero-length captures.
- Both hold their values after done.
- When undefined, these ports and their counters do not exist. All other behaviour is identical.

Decomposition:
- qoi_pkg holds:
  - the QOI opcode constants;
  - the magic bytes;
  - HEADER_LEN=14 and TRAILER_LEN=8;
  - the state enum {IDLE, ENC_RST, HEADER, STREAM, FLUSH, TRAILER}.
- One sub-module, qoi_chunk_serializer, implements the holding register, read index, byte mux and the can_adv output.

Test Plan:
- 1x1, ch=4, cs=0, px 0x000000FF, m_ready=1 → 23 bytes:
  - header 71 6F 69 66 00 00 00 01 00 00 00 01 04 00;
  - body C0;
  - trailer 00×7 01;
  - m_last on byte 23; done pulses once.
- 2x1, both px 0x0A141EFF → body FE 0A 14 1E C0; 27 bytes total.
- 63x1, all px 0x000000FF → body FD C0 (run 62 committed, then run 1).
- Width=0, height=5 → 22 bytes: header with width field 00 00 00 00 and height 00 00 00 05, then the trailer. No enc_ce pulses.
- 2x1 as above, with m_ready=0 for 10 cycles after the FE byte:
  - m_data holds 0x0A throughout;
  - s_ready=0 and enc_ce=0;
  - the final stream is unchanged.
- rst for 1 cycle during STREAM, then start with the 1x1 case:
  - next cycle m_valid=0, busy=0, enc_rst=1;
  - the restarted image produces the exact 23-byte stream.

Source files
------------

// File: rtl/qoi_pkg.sv
// qoi_pkg: QOI opcodes, stream framing constants and controller state encoding
package qoi_pkg;
  localparam logic [7:0] QOI_OP_INDEX = 8'h00;
  localparam logic [7:0] QOI_OP_DIFF  = 8'h40;
  localparam logic [7:0] QOI_OP_LUMA  = 8'h80;
  localparam logic [7:0] QOI_OP_RUN   = 8'hC0;
  localparam logic [7:0] QOI_OP_RGB   = 8'hFE;
  localparam logic [7:0] QOI_OP_RGBA  = 8'hFF;
  localparam logic [31:0] QOI_MAGIC   = 32'h716F6966;
  localparam int HEADER_LEN  = 14;
  localparam int TRAILER_LEN = 8;
  typedef enum logic [2:0] {IDLE, ENC_RST, HEADER, STREAM, FLUSH, TRAILER} state_t;
endpackage

// File: rtl/qoi_chunk_serializer.sv
// qoi_chunk_serializer: holds one encoder chunk of up to 5 bytes and streams it out a byte at a time
module qoi_chunk_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [39:0] chunk,
  input  logic [2:0]  chunk_len,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        can_adv
);
  logic [4:0][7:0] data_q, data_d;
  logic [2:0] len_q, len_d, idx_q, idx_d;
  logic pop, last;
  assign m_valid = len_q != 3'd0;
  assign m_data  = data_q[idx_q];
  assign last    = idx_q == len_q - 3'd1;
  assign pop     = m_valid & m_ready;
  // a new chunk may land in the same cycle the final byte of the old one leaves
  assign can_adv = !m_valid || (last && m_ready);
  always_comb begin
    data_d = load ? chunk : data_q;
    len_d  = load ? chunk_len : (pop && last) ? 3'd0 : len_q;
    idx_d  = (load || (pop && last)) ? 3'd0 : idx_q + 3'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else begin
      data_q <= data_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
    end
  end
endmodule

// File: rtl/qoi_stream_ctrl.sv
// qoi_stream_ctrl: frames one QOI image (header, encoder chunks, end marker) on a byte stream.
// Define QOI_STREAM_CTRL_STATS_EN to add stat_bytes/stat_chunks counters.
module qoi_stream_ctrl
  import qoi_pkg::*;
#(
  parameter int DIM_W     = 32,
  parameter int FLUSH_ADV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic [7:0]       cfg_channels,
  input  logic [7:0]       cfg_colorspace,
  input  logic [31:0]      s_px,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             enc_rst,
  output logic             enc_ce,
  output logic [31:0]      enc_px,
  output logic             enc_finish,
  input  logic [39:0]      enc_chunk,
  input  logic [2:0]       enc_chunk_len,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
`ifdef QOI_STREAM_CTRL_STATS_EN
  output logic [31:0]      stat_bytes,
  output logic [31:0]      stat_chunks,
`endif
  output logic             done
);
  localparam int FW = $clog2(FLUSH_ADV + 1);
  state_t state_q, state_d;
  logic [DIM_W-1:0] cnt_q, cnt_d, width_q, width_d, height_q, height_d;
  logic [7:0] ch_q, ch_d, cs_q, cs_d, ser_data;
  logic [3:0] bidx_q, bidx_d;
  logic [FW-1:0] flush_q, flush_d;
  logic enc_rst_q, done_q, done_d, ser_valid, can_adv, acc, hdr_last, trl_last;
  logic [13:0][7:0] hdr;
  qoi_chunk_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (enc_ce),
    .chunk     (enc_chunk),
    .chunk_len (enc_chunk_len),
    .m_ready   (m_ready),
    .m_data    (ser_data),
    .m_valid   (ser_valid),
    .can_adv   (can_adv)
  );
  assign hdr      = {QOI_MAGIC, 32'(width_q), 32'(height_q), ch_q, cs_q};
  assign hdr_last = bidx_q == 4'(HEADER_LEN - 1);
  assign trl_last = bidx_q == 4'(TRAILER_LEN - 1);
  assign m_valid  = state_q == HEADER || state_q == TRAILER || ser_valid;
  assign m_data   = state_q == HEADER ? hdr[4'(HEADER_LEN - 1) - bidx_q]
                  : state_q == TRAILER ? {7'd0, trl_last} : ser_data;
  assign m_last   = state_q == TRAILER && trl_last;
  assign acc      = m_valid & m_ready;
  assign busy     = state_q != IDLE;
  assign enc_rst  = enc_rst_q;
  assign done     = done_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    width_d    = width_q;
    height_d   = height_q;
    ch_d       = ch_q;
    cs_d       = cs_q;
    bidx_d     = bidx_q;
    flush_d    = flush_q;
    done_d     = 1'b0;
    s_ready    = 1'b0;
    enc_ce     = 1'b0;
    enc_px     = '0;
    enc_finish = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        width_d  = cfg_width;
        height_d = cfg_height;
        ch_d     = cfg_channels;
        cs_d     = cfg_colorspace;
        cnt_d    = cfg_width * cfg_height;
        state_d  = ENC_RST;
      end
      ENC_RST: begin
        bidx_d  = '0;
        state_d = HEADER;
      end
      HEADER: if (acc) begin
        bidx_d  = hdr_last ? 4'd0 : bidx_q + 4'd1;
        state_d = !hdr_last ? HEADER : cnt_q != '0 ? STREAM : TRAILER;
      end
      STREAM: begin
        s_ready = can_adv;
        enc_ce  = s_valid & can_adv;
        enc_px  = s_px;
        if (enc_ce) begin
          cnt_d   = cnt_q - 1'b1;
          flush_d = '0;
          state_d = cnt_q == DIM_W'(1) ? FLUSH : STREAM;
        end
      end
      FLUSH: begin
        if (flush_q != FW'(FLUSH_ADV)) begin
          enc_ce     = can_adv;
          enc_finish = can_adv && flush_q == '0;
          flush_d    = can_adv ? flush_q + 1'b1 : flush_q;
        end else if (!ser_valid) begin
          bidx_d  = '0;
          state_d = TRAILER;
        end
      end
      TRAILER: if (acc) begin
        bidx_d  = bidx_q + 4'd1;
        done_d  = trl_last;
        state_d = trl_last ? IDLE : TRAILER;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      width_q   <= '0;
      height_q  <= '0;
      ch_q      <= '0;
      cs_q      <= '0;
      bidx_q    <= '0;
      flush_q   <= '0;
      enc_rst_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      width_q   <= width_d;
      height_q  <= height_d;
      ch_q      <= ch_d;
      cs_q      <= cs_d;
      bidx_q    <= bidx_d;
      flush_q   <= flush_d;
      enc_rst_q <= state_d == ENC_RST;
      done_q    <= done_d;
    end
  end
`ifdef QOI_STREAM_CTRL_STATS_EN
  logic [31:0] bytes_q, bytes_d, chunks_q, chunks_d;
  logic clr;
  assign clr = state_q == IDLE && start;
  always_comb begin
    bytes_d  = clr ? 32'd0 : bytes_q + 32'(acc);
    chunks_d = clr ? 32'd0 : chunks_q + 32'(enc_ce && enc_chunk_len != 3'd0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bytes_q  <= '0;
      chunks_q <= '0;
    end else begin
      bytes_q  <= bytes_d;
      chunks_q <= chunks_d;
    end
  end
  assign stat_bytes  = bytes_q;
  assign stat_chunks = chunks_q;
`endif
endmodule

// File: tb/tb_qoi_stream_ctrl.sv
// tb_qoi_stream_ctrl: directed bench with a small opaque-pixel QOI encoder stand-in (run and RGB chunks)
module tb_qoi_stream_ctrl;
  logic clk = 0, rst = 1, start = 0, s_valid = 0, m_ready = 1;
  logic [31:0] cfg_width = 0, cfg_height = 0, s_px = 0;
  logic [7:0] cfg_channels = 8'd4, cfg_colorspace = 8'd0;
  logic s_ready, enc_rst, enc_ce, enc_finish, m_valid, m_last, busy, done;
  logic [31:0] enc_px;
  logic [39:0] enc_chunk = '0;
  logic [2:0] enc_chunk_len = '0;
  logic [7:0] m_data;
`ifdef QOI_STREAM_CTRL_STATS_EN
  logic [31:0] stat_bytes, stat_chunks;
`endif
  int tests = 0, fails = 0;
  logic [7:0] got[$], exp[$];
  int ce_cnt, done_cnt, last_pos, hold_bad, stall_seen;
  bit timed_out;
  always #5 clk = ~clk;
  qoi_stream_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_channels(cfg_channels), .cfg_colorspace(cfg_colorspace), .s_px(s_px), .s_valid(s_valid),
    .s_ready(s_ready), .enc_rst(enc_rst), .enc_ce(enc_ce), .enc_px(enc_px), .enc_finish(enc_finish),
    .enc_chunk(enc_chunk), .enc_chunk_len(enc_chunk_len), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy),
`ifdef QOI_STREAM_CTRL_STATS_EN
    .stat_bytes(stat_bytes), .stat_chunks(stat_chunks),
`endif
    .done(done)
  );
  // encoder stand-in: output chunk is registered, so it appears one advance after its pixel
  logic [31:0] em_prev = 32'h000000FF;
  logic [5:0] em_run = 0;
  logic em_fin = 0;
  always @(posedge clk) begin
    if (enc_rst) begin
      em_prev <= 32'h000000FF; em_run <= 0; em_fin <= 0; enc_chunk <= '0; enc_chunk_len <= '0;
    end else if (enc_ce) begin
      if (em_fin) enc_chunk_len <= 3'd0;
      else if (enc_finish) begin
        em_fin <= 1; em_run <= 0;
        enc_chunk <= {32'h0, 2'b11, em_run - 6'd1};
        enc_chunk_len <= (em_run != 0) ? 3'd1 : 3'd0;
      end else if (enc_px == em_prev) begin
        if (em_run == 6'd61) begin
          enc_chunk <= {32'h0, 8'hFD}; enc_chunk_len <= 3'd1; em_run <= 0;
        end else begin
          em_run <= em_run + 6'd1; enc_chunk_len <= 3'd0;
        end
      end else begin
        em_prev <= enc_px; em_run <= 0;
        if (em_run != 0) begin
          enc_chunk <= {enc_px[15:8], enc_px[23:16], enc_px[31:24], 8'hFE, 2'b11, em_run - 6'd1};
          enc_chunk_len <= 3'd5;
        end else begin
          enc_chunk <= {8'h0, enc_px[15:8], enc_px[23:16], enc_px[31:24], 8'hFE};
          enc_chunk_len <= 3'd4;
        end
      end
    end
  end
  task automatic build_exp(input logic [31:0] w, h, input logic [7:0] ch, cs, input logic [39:0] body, input int blen);
    exp = {8'h71, 8'h6F, 8'h69, 8'h66, w[31:24], w[23:16], w[15:8], w[7:0],
           h[31:24], h[23:16], h[15:8], h[7:0], ch, cs};
    for (int i = 0; i < blen; i++) exp.push_back(body[8*i +: 8]);
    repeat (7) exp.push_back(8'h00);
    exp.push_back(8'h01);
  endtask
  task automatic start_image(input logic [31:0] w, h, px, input logic [7:0] ch, cs);
    @(negedge clk);
    cfg_width = w; cfg_height = h; cfg_channels = ch; cfg_colorspace = cs;
    s_px = px; s_valid = 1; m_ready = 1; start = 1;
    got.delete(); ce_cnt = 0; done_cnt = 0; last_pos = -1; hold_bad = 0; stall_seen = 0;
    @(negedge clk);
    start = 0;
  endtask
  task automatic run_until_done(input int stall_at, input int stall_n);
    int stall_left = 0, tail = 0;
    bit fin = 0;
    for (int cyc = 0; cyc < 3000 && tail < 4; cyc++) begin
      m_ready = stall_left == 0;
      #1;
      if (stall_left > 0) begin
        stall_seen++;
        if (m_data !== 8'h0A || m_valid !== 1'b1 || s_ready !== 1'b0 || enc_ce !== 1'b0) hold_bad++;
        stall_left--;
      end
      if (enc_ce) ce_cnt++;
      if (done) begin done_cnt++; fin = 1; end
      if (m_valid && m_ready) begin
        if (m_last) last_pos = got.size();
        got.push_back(m_data);
        if (got.size() == stall_at) stall_left = stall_n;
      end
      if (fin) tail++;
      @(negedge clk);
    end
    m_ready = 1;
    timed_out = !fin;
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got %0b exp 0", m_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b exp 0", busy); end
    tests++; if (enc_rst !== 1'b1) begin fails++; $display("FAIL reset_enc_rst got %0b exp 1", enc_rst); end
    tests++; if ({s_ready, enc_ce, enc_finish, m_last, done} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl got %05b exp 00000", {s_ready, enc_ce, enc_finish, m_last, done});
    end
    rst = 0;
  endtask
  task automatic test_1x1;
    start_image(1, 1, 32'h000000FF, 8'd4, 8'd0);
    run_until_done(0, 0);
    build_exp(1, 1, 8'd4, 8'd0, 40'hC0, 1);
    tests++; if (timed_out) begin fails++; $display("FAIL 1x1_timeout got %0d bytes exp done", got.size()); end
    tests++; if (got.size() != exp.size()) begin fails++; $display("FAIL 1x1_len got %0d exp %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++; if (got[i] !== exp[i]) begin fails++; $display("FAIL 1x1_byte%0d got %02h exp %02h", i, got[i], exp[i]); end
    end
    tests++; if (last_pos != 22) begin fails++; $display("FAIL 1x1_m_last got %0d exp 22", last_pos); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL 1x1_done got %0d exp 1", done_cnt); end
    tests++; if (ce_cnt != 3) begin fails++; $display("FAIL 1x1_ce got %0d exp 3", ce_cnt); end
`ifdef QOI_STREAM_CTRL_STATS_EN
    tests++; if (stat_bytes !== 32'd23) begin fails++; $display("FAIL 1x1_stat_bytes got %0d exp 23", stat_bytes); end
    tests++; if (stat_chunks !== 32'd1) begin fails++; $display("FAIL 1x1_stat_chunks got %0d exp 1", stat_chunks); end
`endif
  endtask
  task automatic test_2x1;
    start_image(2, 1, 32'h0A141EFF, 8'd3, 8'd1);
    run_until_done(0, 0);
    build_exp(2, 1, 8'd3, 8'd1, 40'hC0_1E_14_0A_FE, 5);
    tests++; if (got.size() != 27) begin fails++; $display("FAIL 2x1_len got %0d exp 27", got.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++; if (got[i] !== exp[i]) begin fails++; $display("FAIL 2x1_byte%0d got %02h exp %02h", i, got[i], exp[i]); end
    end
    tests++; if (last_pos != 26 || done_cnt != 1) begin fails++; $display("FAIL 2x1_end got last %0d done %0d exp 26 1", last_pos, done_cnt); end
  endtask
  task automatic test_run63;
    start_image(63, 1, 32'h000000FF, 8'd4, 8'd0);
    run_until_done(0, 0);
    build_exp(63, 1, 8'd4, 8'd0, 40'hC0FD, 2);
    tests++; if (got.size() != exp.size()) begin fails++; $display("FAIL run63_len got %0d exp %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++; if (got[i] !== exp[i]) begin fails++; $display("FAIL run63_byte%0d got %02h exp %02h", i, got[i], exp[i]); end
    end
    tests++; if (ce_cnt != 65) begin fails++; $display("FAIL run63_ce got %0d exp 65", ce_cnt); end
  endtask
  task automatic test_zero_width;
    start_image(0, 5, 32'h000000FF, 8'd4, 8'd0);
    run_until_done(0, 0);
    build_exp(0, 5, 8'd4, 8'd0, 40'h0, 0);
    tests++; if (got.size() != 22) begin fails++; $display("FAIL zero_len got %0d exp 22", got.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++; if (got[i] !== exp[i]) begin fails++; $display("FAIL zero_byte%0d got %02h exp %02h", i, got[i], exp[i]); end
    end
    tests++; if (ce_cnt != 0) begin fails++; $display("FAIL zero_ce got %0d exp 0", ce_cnt); end
    tests++; if (last_pos != 21 || done_cnt != 1) begin fails++; $display("FAIL zero_end got last %0d done %0d exp 21 1", last_pos, done_cnt); end
  endtask
  task automatic test_backpressure;
    start_image(2, 1, 32'h0A141EFF, 8'd4, 8'd0);
    run_until_done(15, 10);
    build_exp(2, 1, 8'd4, 8'd0, 40'hC0_1E_14_0A_FE, 5);
    tests++; if (stall_seen != 10) begin fails++; $display("FAIL bp_stall_cycles got %0d exp 10", stall_seen); end
    tests++; if (hold_bad != 0) begin fails++; $display("FAIL bp_hold got %0d bad cycles exp 0", hold_bad); end
    tests++; if (got.size() != exp.size()) begin fails++; $display("FAIL bp_len got %0d exp %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++; if (got[i] !== exp[i]) begin fails++; $display("FAIL bp_byte%0d got %02h exp %02h", i, got[i], exp[i]); end
    end
  endtask
  task automatic test_reset_mid;
    bit seen_ce = 0, seen_last = 0;
    start_image(2, 1, 32'h0A141EFF, 8'd4, 8'd0);
    for (int cyc = 0; cyc < 100 && !seen_ce; cyc++) begin
      #1;
      if (m_last) seen_last = 1;
      if (enc_ce) seen_ce = 1;
      else @(negedge clk);
    end
    tests++; if (!seen_ce) begin fails++; $display("FAIL mid_reach_stream got no enc_ce exp enc_ce"); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    tests++; if (m_valid !== 1'b0 || busy !== 1'b0 || enc_rst !== 1'b1) begin
      fails++; $display("FAIL mid_reset got v%0b b%0b r%0b exp v0 b0 r1", m_valid, busy, enc_rst);
    end
    tests++; if (seen_last) begin fails++; $display("FAIL mid_abandon got m_last exp none"); end
    start_image(1, 1, 32'h000000FF, 8'd4, 8'd0);
    run_until_done(0, 0);
    build_exp(1, 1, 8'd4, 8'd0, 40'hC0, 1);
    tests++; if (got.size() != exp.size()) begin fails++; $display("FAIL mid_len got %0d exp %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++; if (got[i] !== exp[i]) begin fails++; $display("FAIL mid_byte%0d got %02h exp %02h", i, got[i], exp[i]); end
    end
    tests++; if (last_pos != 22 || done_cnt != 1) begin fails++; $display("FAIL mid_end got last %0d done %0d exp 22 1", last_pos, done_cnt); end
  endtask
  initial begin
    test_reset;
    test_1x1;
    test_2x1;
    test_run63;
    test_zero_width;
    test_backpressure;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
